// File: rtl/ip_uart_tx.sv
// 8N1 UART transmitter, LSB first, behind a send_req/send_busy handshake.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO between the handshake and the shifter.
module ip_uart_tx #(
    parameter int CLK_FREQ   = 75000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] send_data,
    input  logic       send_req,
    output logic       send_busy,
    output logic       uart_tx
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("ip_uart_tx: bit period DIV must be at least 2 clocks");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic       accept;
    logic       byte_avail;
    logic [7:0] load_byte;
    logic       bit_end;
    logic       load;

    assign accept  = send_req && !busy_q;
    assign bit_end = (cnt_q == CNT_LAST);
    // The shifter takes a new byte from IDLE, or straight from the end of a stop bit.
    assign load    = byte_avail && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("ip_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    assign byte_avail = (count_q != '0);
    assign load_byte  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({accept, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        busy_d = (count_d == FULL);
    end

    // NOTE: the storage array carries no reset; pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= send_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
`else
    assign byte_avail = accept;
    assign load_byte  = send_data;

    // Busy spans the whole frame; it drops on the edge that ends the stop bit.
    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if ((state_q == S_STOP) && bit_end) begin
            busy_d = 1'b0;
        end
    end

    logic unused_fifo_depth;
    assign unused_fifo_depth = (FIFO_DEPTH > 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: each combinational output is given a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (load) state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = load ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = tx_q;
        sh_d = sh_q;
        if (load) begin
            tx_d = 1'b0;
            sh_d = load_byte;
        end else if (bit_end) begin
            case (state_q)
                S_START: tx_d = sh_q[0];
                S_DATA: begin
                    if (idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        sh_d = {1'b0, sh_q[7:1]};
                        tx_d = sh_q[1];
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign uart_tx   = tx_q;
    assign send_busy = busy_q;

endmodule

// File: tb/tb_ip_uart_tx.sv
// Directed bench for ip_uart_tx at DIV = 10; the FIFO sections build when UART_TX_FIFO_EN is defined.
module tb_ip_uart_tx;

    localparam int NV = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] send_data;
    logic       send_req;
    logic       send_busy;
    logic       uart_tx;

    ip_uart_tx #(
        .CLK_FREQ  (1000000),
        .BAUD      (100000),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .send_data(send_data),
        .send_req (send_req),
        .send_busy(send_busy),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] ok_bytes  [4];
    logic [9:0] ok_frames [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line monitor: samples each bit in the middle of its period.
    logic       mon_en = 1'b0;
    logic [9:0] rx_frames [$];
    int         rx_start  [$];

    initial begin : rx_monitor
        logic [9:0] f;
        int         st;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && (uart_tx === 1'b0)) begin
                st = cyc;
                repeat (5) @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    f[k] = uart_tx;
                    if (k < 9) repeat (10) @(negedge clk);
                end
                rx_frames.push_back(f);
                rx_start.push_back(st);
            end
        end
    end

    task automatic check_rx(input int k, input logic [9:0] exp, input string name);
        if (k < rx_frames.size()) begin
            check(name, rx_frames[k], exp);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: frame missing, expected 0x%0h", name, exp);
        end
    endtask

    // Sender side of the handshake: holds send_req until an edge with send_busy low.
    task automatic send_byte(input logic [7:0] d, output int acc_cyc);
        logic pre;
        bit   done;
        done    = 1'b0;
        acc_cyc = -1;
        send_req  = 1'b1;
        send_data = d;
        for (int n = 0; (n < 3000) && !done; n++) begin
            pre = send_busy;
            tick();
            if (!pre) begin
                done     = 1'b1;
                acc_cyc  = cyc;
                send_req = 1'b0;
            end
        end
        if (!done) begin
            send_req = 1'b0;
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: byte 0x%0h never accepted", d);
        end
    endtask

    task automatic wait_frames(input int n, input string name);
        for (int k = 0; (k < 4000) && (rx_frames.size() < n); k++) tick();
        repeat (120) tick();
        check({name, "_count"}, rx_frames.size(), n);
    endtask

`ifndef UART_TX_FIFO_EN
    // Called at accept edge + 1; walks the 100 clocks of one frame.
    task automatic capture_frame(input int req_at, input logic [7:0] req_byte,
                                 output logic [9:0] frame, output logic stable,
                                 output logic busy_ok);
        stable  = 1'b1;
        busy_ok = 1'b1;
        frame   = '0;
        for (int c = 0; c < 100; c++) begin
            if ((c % 10) == 0)                stable = stable;
            if ((c % 10) == 0)                frame[c / 10] = uart_tx;
            else if (uart_tx !== frame[c / 10]) stable = 1'b0;
            if (send_busy !== 1'b1)           busy_ok = 1'b0;
            if (c == req_at) begin
                send_req  = 1'b1;
                send_data = req_byte;
            end
            tick();
        end
    endtask
`endif

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin : main
        int acc;
        int e;

        vecs[0] = '{data: 8'h50, frame: 10'h2A0};
        vecs[1] = '{data: 8'hA5, frame: 10'h34A};
        vecs[2] = '{data: 8'h00, frame: 10'h200};
        vecs[3] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[4] = '{data: 8'h01, frame: 10'h202};
        vecs[5] = '{data: 8'h80, frame: 10'h300};
        ok_bytes  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        ok_frames = '{10'h29E, 10'h296, 10'h21A, 10'h214};

        // Reset held for 3 clocks with a pending request.
        reset     = 1'b1;
        send_req  = 1'b1;
        send_data = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("reset_tx[%0d]", k), uart_tx, 1'b1);
            check($sformatf("reset_busy[%0d]", k), send_busy, 1'b0);
        end
        reset    = 1'b0;
        send_req = 1'b0;
        tick();
        check("post_reset_idle_tx", uart_tx, 1'b1);
        repeat (3) tick();

`ifndef UART_TX_FIFO_EN
        begin : no_fifo_tests
            logic [9:0] frame;
            logic       stable;
            logic       busy_ok;
            int         prev_acc;
            prev_acc = 0;

            // Back-to-back bytes at the minimum byte period.
            for (int i = 0; i < NV; i++) begin
                send_byte(vecs[i].data, acc);
                if (i > 0) check($sformatf("byte_period[%0d]", i), acc - prev_acc, 101);
                check($sformatf("start_low[%0d]", i), uart_tx, 1'b0);
                capture_frame(-1, 8'h00, frame, stable, busy_ok);
                check($sformatf("frame[%0d]", i), frame, vecs[i].frame);
                check($sformatf("frame_stable[%0d]", i), stable, 1'b1);
                check($sformatf("busy_window[%0d]", i), busy_ok, 1'b1);
                check($sformatf("busy_release[%0d]", i), send_busy, 1'b0);
                check($sformatf("stop_idle[%0d]", i), uart_tx, 1'b1);
                prev_acc = acc;
            end
            repeat (5) tick();

            // Request held while busy: 0x4B must wait for edge E + 101.
            send_byte(8'h4F, e);
            capture_frame(2, 8'h4B, frame, stable, busy_ok);
            check("rwb_frame0", frame, 10'h29E);
            check("rwb_busy0", busy_ok, 1'b1);
            check("rwb_not_early", send_busy, 1'b0);
            tick();
            check("rwb_accept_busy", send_busy, 1'b1);
            check("rwb_accept_start", uart_tx, 1'b0);
            send_req = 1'b0;
            capture_frame(-1, 8'h00, frame, stable, busy_ok);
            check("rwb_frame1", frame, 10'h296);
            check("rwb_stable1", stable, 1'b1);
            repeat (5) tick();
        end
`else
        begin : fifo_tests
            int i;
            int first_busy;
            int pushed_at_full;

            // 20 bytes pushed at the maximum rate with send_req held high.
            rx_frames.delete();
            rx_start.delete();
            mon_en         = 1'b1;
            i              = 0;
            e              = -1;
            first_busy     = -1;
            pushed_at_full = -1;
            send_req       = 1'b1;
            for (int n = 0; (n < 3000) && (i < 20); n++) begin
                logic pre;
                send_data = 8'(i);
                pre = send_busy;
                tick();
                if (!pre) begin
                    if (i == 0) e = cyc;
                    i++;
                end
                if ((first_busy < 0) && send_busy) begin
                    first_busy     = cyc;
                    pushed_at_full = i;
                end
            end
            send_req = 1'b0;
            check("fifo_pushed", i, 20);
            check("fifo_full_edge", first_busy - e, 16);
            check("fifo_full_count", pushed_at_full, 17);
            wait_frames(20, "fifo20");
            for (int k = 0; k < 20; k++) begin
                check_rx(k, {1'b1, 8'(k), 1'b0}, $sformatf("fifo20_frame[%0d]", k));
                if (k < rx_start.size())
                    check($sformatf("fifo20_start[%0d]", k), rx_start[k] - e, 1 + 100 * k);
            end

            // Table vectors through the FIFO.
            rx_frames.delete();
            rx_start.delete();
            for (int k = 0; k < NV; k++) begin
                send_byte(vecs[k].data, acc);
                tick();
            end
            wait_frames(NV, "vec");
            for (int k = 0; k < NV; k++) check_rx(k, vecs[k].frame, $sformatf("vec_frame[%0d]", k));
        end
`endif

        // Asynchronous reset 35 clocks into the 0xFF frame.
        mon_en = 1'b0;
        send_byte(8'hFF, e);
`ifdef UART_TX_FIFO_EN
        repeat (36) tick();
`else
        repeat (35) tick();
        check("mid_frame_busy", send_busy, 1'b1);
`endif
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx", uart_tx, 1'b1);
        check("async_rst_busy", send_busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        rx_frames.delete();
        rx_start.delete();
        mon_en = 1'b1;
        send_byte(8'h0D, acc);
        wait_frames(1, "after_rst");
        check_rx(0, 10'h21A, "after_rst_frame");

        // Sender emulation of "OK\r\n": drop on accept, re-raise one clock later.
        rx_frames.delete();
        rx_start.delete();
        for (int k = 0; k < 4; k++) begin
            send_byte(ok_bytes[k], acc);
            tick();
        end
        wait_frames(4, "ok");
        for (int k = 0; k < 4; k++) check_rx(k, ok_frames[k], $sformatf("ok_frame[%0d]", k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ip_uart_tx.md
# ip_uart_tx

- Byte-serial UART transmitter, 8N1, LSB first. It is the far end of the `send_data` / `send_req` / `send_busy` interface driven by the PSRAM test sequencer.
- It serialises each accepted byte onto `uart_tx` at a fixed baud rate derived from the system clock.
- It sits between the test sequencer and the board's USB-UART bridge pin.

## Interface
- `CLK_FREQ`, default 75000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 16: byte FIFO depth, power of two ≥ 2. Used only with `UART_TX_FIFO_EN`.
- `clk`  in  1  system clock. One clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `send_data`  in  8  byte to transmit; sampled only on an accept edge.
- `send_req`  in  1  request; level-held by the sender until it sees `send_busy` = 0.
- `send_busy`  out  1  registered; 1 means the block is not accepting.
- `uart_tx`  out  1  serial line; idle high.

## Operation
- Bit period: `DIV = (CLK_FREQ + BAUD/2) / BAUD`, integer-rounded. The default gives 651.
  - `DIV` ≥ 2 is required; elaboration fails otherwise.
  - Bit counter width is `$clog2(DIV)`.
- Accept rule: a byte is accepted on any rising edge where `send_req` = 1 and `send_busy` = 0. No other condition accepts a byte.
  - `send_busy` rises at that same edge.
  - This guarantees exactly one accept per sender request.
  - The sender drops `send_req` at the same edge and may re-raise it one cycle later with the next byte.
- `send_req` while `send_busy` = 1 is held off, never dropped or corrupted. Acceptance happens on the first edge after `send_busy` falls.
- Shifter FSM has four states: IDLE, START, DATA, STOP.
  - IDLE → START on a byte available: the accept edge without FIFO, or FIFO non-empty with FIFO. At that edge `uart_tx` <= 0 and the shift register is loaded.
  - START → DATA after `DIV` clocks. Bit index is 0; `uart_tx` <= `sh[0]`.
  - DATA: every `DIV` clocks, shift right and increment the index. After bit 7's period, go to STOP with `uart_tx` <= 1.
  - STOP: after `DIV` clocks, return to IDLE. With FIFO, if the FIFO is non-empty, go straight to START instead (pop and load at that edge).
- Frame = 10 × `DIV` clocks. `uart_tx` holds 1 in IDLE.
- Reset, asynchronous, any time including mid-frame:
  - FSM → IDLE; counters cleared; FIFO pointers cleared.
  - `uart_tx` = 1 and `send_busy` = 0 immediately.
  - The partially sent frame is abandoned with no completion.

## Timing
- Reset values: `uart_tx` = 1, `send_busy` = 0.
- Without FIFO:
  - Accept at edge E: `uart_tx` low from E; `send_busy` = 1 over [E, E + 10·`DIV`).
  - At edge E + 10·`DIV`: FSM → IDLE, `send_busy` <= 0.
  - The earliest next accept is E + 10·`DIV` + 1, so the minimum byte period is 10·`DIV` + 1 clocks.
- With FIFO:
  - Accept = push. `send_busy` is registered as (count after this edge == `FIFO_DEPTH`).
  - Pop happens on the IDLE→START or STOP→START edge. A byte pushed into an empty FIFO while IDLE starts its start bit one clock after the push edge.
  - A simultaneous push and pop on a full FIFO leaves count unchanged. That case is unreachable, because `send_busy` blocks the push.
  - Back-to-back frames have zero idle clocks while the FIFO is non-empty.

## Configuration
- `UART_TX_FIFO_EN`
  - Defined: a `FIFO_DEPTH`-entry byte FIFO sits between the accept port and the shifter. `send_busy` means FIFO full; the sender can queue a whole message without waiting per byte.
  - Undefined: no FIFO, single shift register. `send_busy` = frame in progress, with the timing above. `FIFO_DEPTH` is ignored.

## Test plan
All cases use `CLK_FREQ` = 1000000 and `BAUD` = 100000, so `DIV` = 10.
- Reset: assert `reset` for 3 clocks with `send_req` = 1 → `uart_tx` = 1 and `send_busy` = 0 throughout; no frame starts while reset is high.
- Single byte 0x50, no FIFO → `uart_tx` runs 0 | 0 0 0 0 1 0 1 0 | 1, each level 10 clocks. `send_busy` is high exactly 100 clocks from the accept edge.
- Request while busy: send 0x4F, then hold `send_req` with 0x4B from cycle 2 → 0x4B is accepted at edge E + 101. The line shows frames 0x4F then 0x4B, each correct.
- Async reset mid-frame: reset asserted 35 clocks into the 0xFF frame → `uart_tx` = 1 and `send_busy` = 0 without a clock edge. A following 0x0D is sent correctly.
- FIFO (macro defined, `FIFO_DEPTH` = 16): push 0x00–0x13 at maximum rate → `send_busy` asserts once 16 bytes are queued. All 20 bytes appear in order, frames contiguous, last stop bit ends 200 × 10 + 1 clocks after the first push.
- Sender emulation of "OK\r\n" (0x4F 0x4B 0x0D 0x0A), with `send_req` dropped on the accept edge and re-raised one clock later → exactly 4 frames, no duplicates, in both configurations.
